// File: rtl/lfsr_step_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : lfsr_step_ctrl
// Purpose  : Sequencer for the 8-bit LFSR display path (LFSR + two hex digits).
//            Converts raw load/step buttons and a run switch into single-cycle
//            load/step strobes. It also:
//              - replaces an all-zero seed with a legal one,
//              - paces free-run stepping,
//              - gates the display,
//              - flags when the sequence returns to its seed.
// Build    : define DEBOUNCE_EN to put a DB_MAX+1 cycle stability filter behind
//            each input synchronizer. Without it, edges are taken directly from
//            the synchronizer outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous, active-high reset
//   btn_load    in   1  raw load button (asynchronous)
//   btn_step    in   1  raw step button (asynchronous)
//   run_en      in   1  raw run switch, level (asynchronous)
//   seed        in   8  seed value, sampled when a load is accepted
//   lfsr_q      in   8  current LFSR value fed back from the LFSR
//   lfsr_load   out  1  1-cycle strobe: LFSR takes lfsr_din
//   lfsr_din    out  8  registered seed to load
//   lfsr_step   out  1  1-cycle strobe: LFSR shifts once
//   disp_en     out  1  display enable for both digits
//   step_cnt    out  8  steps since last load, saturating at 8'hFF
//   period_hit  out  1  sticky: LFSR came back to the loaded seed
//==============================================================================
module lfsr_step_ctrl #(
  parameter int unsigned      DIV_W   = 20,
  parameter logic [DIV_W-1:0] DIV_MAX = 20'd999_999,
  parameter int unsigned      DB_W    = 16,
  parameter logic [DB_W-1:0]  DB_MAX  = 16'd49_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_load,
  input  logic       btn_step,
  input  logic       run_en,
  input  logic [7:0] seed,
  input  logic [7:0] lfsr_q,
  output logic       lfsr_load,
  output logic [7:0] lfsr_din,
  output logic       lfsr_step,
  output logic       disp_en,
  output logic [7:0] step_cnt,
  output logic       period_hit
);

  // Bit positions of the three control inputs inside the packed vectors.
  localparam int unsigned IN_LOAD = 0;
  localparam int unsigned IN_STEP = 1;
  localparam int unsigned IN_RUN  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  //--------------------------------------------------------------------------
  // Input synchronizers (two flops per input)
  //--------------------------------------------------------------------------
  logic [2:0] raw_in;
  logic [2:0] sync1_d, sync1_q;
  logic [2:0] sync2_d, sync2_q;

  assign raw_in = {run_en, btn_step, btn_load};

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  //--------------------------------------------------------------------------
  // Clean input level: debounced or straight from the synchronizers
  //--------------------------------------------------------------------------
  logic [2:0] lvl;

`ifdef DEBOUNCE_EN
  // The filtered level follows the synchronized input only after it has
  // disagreed with the filtered level for DB_MAX+1 consecutive cycles. Any
  // cycle of agreement restarts the count, so short glitches are swallowed.
  logic [2:0]           flt_d, flt_q;
  logic [2:0][DB_W-1:0] db_cnt_d, db_cnt_q;

  always_comb begin
    flt_d    = flt_q;
    db_cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != flt_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          flt_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_q    <= '0;
      db_cnt_q <= '0;
    end else begin
      flt_q    <= flt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign lvl = flt_q;
`else
  assign lvl = sync2_q;
`endif

  //--------------------------------------------------------------------------
  // Rising-edge detection for the two buttons (run_en is used as a level)
  //--------------------------------------------------------------------------
  logic [1:0] prev_d, prev_q;
  logic       load_edge;
  logic       step_edge;
  logic       run_lvl;

  always_comb begin
    prev_d = lvl[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign load_edge = lvl[IN_LOAD] & ~prev_q[IN_LOAD];
  assign step_edge = lvl[IN_STEP] & ~prev_q[IN_STEP];
  assign run_lvl   = lvl[IN_RUN];

  //--------------------------------------------------------------------------
  // Sequencer state and registered outputs
  //--------------------------------------------------------------------------
  state_t           state_d, state_q;
  logic [DIV_W-1:0] div_cnt_d, div_cnt_q;
  logic [7:0]       seed_r_d, seed_r_q;
  logic [7:0]       step_cnt_d, step_cnt_q;
  logic             period_hit_d, period_hit_q;
  logic             lfsr_load_d, lfsr_load_q;
  logic             lfsr_step_d, lfsr_step_q;
  logic             step_dly_d, step_dly_q;
  logic             disp_en_d, disp_en_q;

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    seed_r_d     = seed_r_q;
    step_cnt_d   = step_cnt_q;
    period_hit_d = period_hit_q;
    lfsr_load_d  = 1'b0;
    lfsr_step_d  = 1'b0;

    // Priority within each state: load edge, then run level, then step edge.
    case (state_q)
      ST_IDLE: begin
        if (load_edge) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = run_lvl ? ST_RUN : ST_READY;
      end
      ST_READY: begin
        if (load_edge) begin
          state_d = ST_LOAD;
        end else if (run_lvl) begin
          state_d = ST_RUN;
        end else if (step_edge) begin
          lfsr_step_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (load_edge) begin
          state_d = ST_LOAD;
        end else if (!run_lvl) begin
          state_d   = ST_READY;
          div_cnt_d = '0;
        end else if (div_cnt_q == DIV_MAX) begin
          lfsr_step_d = 1'b1;
          div_cnt_d   = '0;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_LOAD) begin
      // Entering LOAD: the strobe comes out together with the state. An
      // all-zero seed would lock the LFSR, so it is replaced by 8'h01.
      lfsr_load_d  = 1'b1;
      seed_r_d     = (seed == 8'h00) ? 8'h01 : seed;
      step_cnt_d   = '0;
      period_hit_d = 1'b0;
      div_cnt_d    = '0;
    end else begin
      if (lfsr_step_d && (step_cnt_q != 8'hFF)) begin
        step_cnt_d = step_cnt_q + 8'd1;
      end
      // step_dly_q marks the first cycle in which lfsr_q shows the shifted
      // value. A step that was followed by a load is stale; the LOAD-state
      // guard discards it.
      if (step_dly_q && (state_q != ST_LOAD) && (lfsr_q == seed_r_q)) begin
        period_hit_d = 1'b1;
      end
    end

    step_dly_d = lfsr_step_q;
    disp_en_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      seed_r_q     <= '0;
      step_cnt_q   <= '0;
      period_hit_q <= 1'b0;
      lfsr_load_q  <= 1'b0;
      lfsr_step_q  <= 1'b0;
      step_dly_q   <= 1'b0;
      disp_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      seed_r_q     <= seed_r_d;
      step_cnt_q   <= step_cnt_d;
      period_hit_q <= period_hit_d;
      lfsr_load_q  <= lfsr_load_d;
      lfsr_step_q  <= lfsr_step_d;
      step_dly_q   <= step_dly_d;
      disp_en_q    <= disp_en_d;
    end
  end

  assign lfsr_load  = lfsr_load_q;
  assign lfsr_din   = seed_r_q;
  assign lfsr_step  = lfsr_step_q;
  assign disp_en    = disp_en_q;
  assign step_cnt   = step_cnt_q;
  assign period_hit = period_hit_q;

endmodule
`default_nettype wire
